// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared definitions for the SAP-class CPU (jump conditions, widths)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int DEFAULT_AW = 4;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_CARRY  = 2'b10;
    localparam logic [1:0] COND_NEG    = 2'b11;

    function automatic logic cond_met(input logic [1:0] cond,
                                      input logic zero_f,
                                      input logic carry_f,
                                      input logic neg_f);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_ZERO:   met = zero_f;
            COND_CARRY:  met = carry_f;
            COND_NEG:    met = neg_f;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_unit_stack_if.sv
//------------------------------------------------------------------------------
// pc_unit_stack_if : controller <-> program counter control and status bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_unit_stack_if
    import cpu_pkg::*;
#(
    parameter int AW  = DEFAULT_AW,
    parameter int SPW = 2
);
    logic          Cp;
    logic          Ep;
    logic          Jmp;
    logic [1:0]    Cond;
    logic          Call;
    logic          Ret;
    logic          zero_flag;
    logic          carry_flag;
    logic          neg_flag;
    logic [AW-1:0] Jump_In;
    logic [AW-1:0] PC_val;
    logic [SPW:0]  SP;
    logic          STK_EMPTY;
    logic          STK_FULL;
    logic          STK_ERR;

    modport master (
        output Cp, Ep, Jmp, Cond, Call, Ret,
        output zero_flag, carry_flag, neg_flag, Jump_In,
        input  PC_val, SP, STK_EMPTY, STK_FULL, STK_ERR
    );

    modport slave (
        input  Cp, Ep, Jmp, Cond, Call, Ret,
        input  zero_flag, carry_flag, neg_flag, Jump_In,
        output PC_val, SP, STK_EMPTY, STK_FULL, STK_ERR
    );

endinterface

`default_nettype wire

// File: rtl/ret_stack.sv
//------------------------------------------------------------------------------
// ret_stack : DEPTH x AW return-address LIFO with occupancy and sticky error
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ret_stack #(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic [SPW:0]  sp,
    output logic          full,
    output logic          empty,
    output logic          err
);
    localparam logic [SPW:0] SP_FULL = (SPW+1)'(DEPTH);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] rd_idx;

    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    // Top entry lives at sp-1; the index wraps harmlessly when empty.
    assign rd_idx = sp[SPW-1:0] - 1'b1;
    assign dout   = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            err <= 1'b0;
        end else if (pop) begin
            if (!empty) sp  <= sp - 1'b1;
            else        err <= 1'b1;
        end else if (push) begin
            if (!full)  sp  <= sp + 1'b1;
            else        err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop && !full)
            mem[sp[SPW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/tristate_buf.sv
//------------------------------------------------------------------------------
// tristate_buf : W-bit bus driver, high-Z when not enabled
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tristate_buf #(
    parameter int W = 4
) (
    input  logic         en,
    input  logic [W-1:0] a,
    output wire  [W-1:0] y
);
    assign y = en ? a : {W{1'bz}};
endmodule

`default_nettype wire

// File: rtl/pc_unit_stack.sv
//------------------------------------------------------------------------------
// pc_unit_stack : program counter with conditional jumps and CALL/RET stack
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit_stack
    import cpu_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DEPTH = 4,
    parameter int SPW   = 2
) (
    input  logic            CLK,
    input  logic            CLR,
    pc_unit_stack_if.slave  bus,
    output wire  [AW-1:0]   PC_out
);
    logic [AW-1:0] pc;
    logic [AW-1:0] stk_top;
    logic [SPW:0]  sp;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;
    logic          jmp_taken;

    assign jmp_taken = bus.Jmp &&
                       cond_met(bus.Cond, bus.zero_flag, bus.carry_flag, bus.neg_flag);

    // Ret outranks Call, so the stack sees pop/push with the same priority.
    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_ret_stack (
        .clk   (CLK),
        .rst   (CLR),
        .push  (bus.Call),
        .pop   (bus.Ret),
        .din   (pc),
        .dout  (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc <= '0;
        end else if (bus.Ret) begin
            if (!stk_empty) pc <= stk_top;
        end else if (bus.Call) begin
            if (!stk_full)  pc <= bus.Jump_In;
        end else if (jmp_taken) begin
            pc <= bus.Jump_In;
        end else if (bus.Cp) begin
            pc <= pc + 1'b1;
        end
    end

    assign bus.PC_val    = pc;
    assign bus.SP        = sp;
    assign bus.STK_EMPTY = stk_empty;
    assign bus.STK_FULL  = stk_full;
    assign bus.STK_ERR   = stk_err;

    tristate_buf #(
        .W (AW)
    ) u_bus_drv (
        .en (bus.Ep),
        .a  (pc),
        .y  (PC_out)
    );

endmodule

`default_nettype wire
